// File: rtl/fme_mb_sched.sv
// fme_mb_sched: macroblock scheduler for the fractional motion-estimation engine.
// Accepts a job (base position + sub-block count), issues one engine start per 4x4 sub-block,
// waits for eng_done (or a timeout), and presents each result on a valid/ready handshake.
// All outputs are registered.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready         job request handshake
//   job_base, job_nblk          sub-block 0 position; sub-block count (0 means 16)
//   abort                       synchronous job cancel (ignored while idle)
//   eng_start, eng_pix_pos      one-cycle engine start pulse; position of the current sub-block
//   eng_done, eng_best, eng_val engine completion and its result
//   res_valid/res_ready         result handshake
//   res_idx, res_best, res_val, res_err  captured result and timeout flag
//   busy, job_done              not-idle indicator; one-cycle end-of-job pulse
module fme_mb_sched #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned POS_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [POS_W-1:0] job_base,
    input  logic [4:0]       job_nblk,
    input  logic             abort,
    output logic             eng_start,
    output logic [POS_W-1:0] eng_pix_pos,
    input  logic             eng_done,
    input  logic [3:0]       eng_best,
    input  logic [7:0]       eng_val,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_idx,
    output logic [3:0]       res_best,
    output logic [7:0]       res_val,
    output logic             res_err,
    output logic             busy,
    output logic             job_done
);

    // The timer counts WAIT cycles 0..TIMEOUT-1; the last count without eng_done times out.
    localparam int unsigned       TimerW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StOut, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        nblk_m1_q, nblk_m1_d;
    logic [POS_W-1:0]  base_q, base_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic              job_ready_q, busy_q, eng_start_q, res_valid_q, job_done_q;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [3:0]        res_idx_q, res_idx_d;
    logic [3:0]        res_best_q, res_best_d;
    logic [7:0]        res_val_q, res_val_d;
    logic              res_err_q, res_err_d;

    // Sub-blocks are laid out 4 per row on a 16-pixel-wide frame row: 4*(k%4) + 64*(k/4).
    function automatic logic [POS_W-1:0] blk_offset(input logic [3:0] k);
        logic [7:0] off;
        off = {k[3:2], 2'b00, k[1:0], 2'b00};
        return POS_W'(off);
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        nblk_m1_d  = nblk_m1_q;
        base_d     = base_q;
        timer_d    = timer_q;
        res_idx_d  = res_idx_q;
        res_best_d = res_best_q;
        res_val_d  = res_val_q;
        res_err_d  = res_err_q;

        unique case (state_q)
            StIdle: begin
                // job_ready_q gates acceptance so no job is taken in the first cycle after reset.
                if (job_valid && job_ready_q) begin
                    base_d    = job_base;
                    nblk_m1_d = 4'(job_nblk - 5'd1);  // 0 wraps to 15, i.e. 16 sub-blocks
                    k_d       = '0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (eng_done) begin
                    res_idx_d  = k_q;
                    res_best_d = eng_best;
                    res_val_d  = eng_val;
                    res_err_d  = 1'b0;
                    state_d    = StOut;
                end else if (timer_q == TimerLast) begin
                    res_idx_d  = k_q;
                    res_best_d = '0;
                    res_val_d  = '0;
                    res_err_d  = 1'b1;
                    state_d    = StOut;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StOut: begin
                if (res_valid_q && res_ready) begin
                    if (k_q == nblk_m1_q) begin
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a result handshake in the same cycle.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            k_d     = '0;
        end
    end

    // Position is loaded on every entry to ISSUE and then held through WAIT and OUT.
    always_comb begin
        pos_d = pos_q;
        if (state_d == StIssue) begin
            pos_d = base_d + blk_offset(k_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            nblk_m1_q   <= '0;
            base_q      <= '0;
            timer_q     <= '0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            job_done_q  <= 1'b0;
            pos_q       <= '0;
            res_idx_q   <= '0;
            res_best_q  <= '0;
            res_val_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            nblk_m1_q   <= nblk_m1_d;
            base_q      <= base_d;
            timer_q     <= timer_d;
            // Status outputs are decoded from the next state so they line up with state_q.
            job_ready_q <= (state_d == StIdle);
            busy_q      <= (state_d != StIdle);
            eng_start_q <= (state_d == StIssue);
            res_valid_q <= (state_d == StOut);
            job_done_q  <= (state_d == StDone);
            pos_q       <= pos_d;
            res_idx_q   <= res_idx_d;
            res_best_q  <= res_best_d;
            res_val_q   <= res_val_d;
            res_err_q   <= res_err_d;
        end
    end

    assign job_ready   = job_ready_q;
    assign busy        = busy_q;
    assign eng_start   = eng_start_q;
    assign eng_pix_pos = pos_q;
    assign res_valid   = res_valid_q;
    assign res_idx     = res_idx_q;
    assign res_best    = res_best_q;
    assign res_val     = res_val_q;
    assign res_err     = res_err_q;
    assign job_done    = job_done_q;

endmodule

// File: tb/tb_fme_mb_sched.sv
// Testbench for fme_mb_sched: directed job sequence with randomized engine latency, results and
// result back-pressure, checked against a job-level reference model kept in this bench.
module tb_fme_mb_sched;

    localparam int unsigned TO = 255;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [PW-1:0] job_base;
    logic [4:0]    job_nblk;
    logic          abort;
    logic          eng_start;
    logic [PW-1:0] eng_pix_pos;
    logic          eng_done;
    logic [3:0]    eng_best;
    logic [7:0]    eng_val;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_idx;
    logic [3:0]    res_best;
    logic [7:0]    res_val;
    logic          res_err;
    logic          busy;
    logic          job_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fme_mb_sched #(
        .TIMEOUT(TO),
        .POS_W  (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_base   (job_base),
        .job_nblk   (job_nblk),
        .abort      (abort),
        .eng_start  (eng_start),
        .eng_pix_pos(eng_pix_pos),
        .eng_done   (eng_done),
        .eng_best   (eng_best),
        .eng_val    (eng_val),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_idx    (res_idx),
        .res_best   (res_best),
        .res_val    (res_val),
        .res_err    (res_err),
        .busy       (busy),
        .job_done   (job_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference position: base + 4*(k mod 4) + 64*(k div 4), modulo 2^PW.
    function automatic logic [PW-1:0] exp_pos(input logic [PW-1:0] base, input int k);
        int unsigned p;
        p = int'(base) + 4 * (k % 4) + 64 * (k / 4);
        return p[PW-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_job_ready"}, job_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_pix_pos"}, eng_pix_pos, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_idx"}, res_idx, 0);
        check({tag, "_res_best"}, res_best, 0);
        check({tag, "_res_val"}, res_val, 0);
        check({tag, "_res_err"}, res_err, 0);
        check({tag, "_job_done"}, job_done, 0);
    endtask

    // mode: 0 = engine done 3 cycles after start, 1 = random latency 1..8, 2 = engine silent.
    // stall_cfg: >=0 random res_ready stall 0..stall_cfg, <0 fixed stall of -stall_cfg cycles.
    // kill_kind: 0 none, 1 abort in WAIT of sub-block kill_k, 2 reset in OUT of sub-block kill_k.
    task automatic run_job(input logic [PW-1:0] base, input logic [4:0] nblk, input int mode,
                           input int stall_cfg, input int kill_kind, input int kill_k);
        int   n, k_start, k_res, cyc, start_cyc, lat, done_at, abort_at;
        int   stall_left, exp_start_at, exp_done_at, guard;
        logic [3:0] e_best;
        logic [7:0] e_val;
        logic       e_err;
        bit         fin, stall_set;

        n = (nblk == 5'd0) ? 16 : int'(nblk);
        k_start = 0; k_res = 0; start_cyc = 0; lat = 0; done_at = -1; abort_at = -1;
        stall_left = 0; exp_done_at = -1; e_best = '0; e_val = '0; e_err = 1'b0;
        fin = 1'b0; stall_set = 1'b0;

        guard = 0;
        while (job_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("job_ready_idle", job_ready, 1);
        job_valid = 1'b1;
        job_base  = base;
        job_nblk  = nblk;
        tick();
        job_valid = 1'b0;
        job_base  = PW'($urandom);
        job_nblk  = 5'($urandom);
        check("job_ready_busy", job_ready, 0);

        cyc = 0;
        exp_start_at = 0;
        while (!fin && cyc < 20000) begin
            eng_done  = 1'b0;
            eng_best  = 4'($urandom);
            eng_val   = 8'($urandom);
            res_ready = 1'b0;
            abort     = 1'b0;
            check("busy", busy, 1);
            if (cyc == exp_start_at) check("start_timing", eng_start, 1);
            if (eng_start === 1'b1) begin
                check("start_after_handshake", k_res, k_start);
                check($sformatf("pos_k%0d", k_start), eng_pix_pos, exp_pos(base, k_start));
                start_cyc = cyc;
                lat       = (mode == 0) ? 3 : int'($urandom_range(8, 1));
                e_err     = (mode == 2);
                e_best    = e_err ? 4'd0 : 4'($urandom);
                e_val     = e_err ? 8'd0 : 8'($urandom);
                done_at   = e_err ? -1 : cyc + lat;
                if (kill_kind == 1 && k_start == kill_k) begin
                    done_at  = -1;
                    abort_at = cyc + 1;
                end
                k_start++;
            end
            if (cyc == done_at) begin
                eng_done = 1'b1;
                eng_best = e_best;
                eng_val  = e_val;
            end
            if (cyc == abort_at) abort = 1'b1;
            if (res_valid === 1'b1) begin
                if (!stall_set) begin
                    check("res_latency", cyc - start_cyc, e_err ? TO + 1 : lat + 1);
                    stall_left = (stall_cfg < 0) ? -stall_cfg : int'($urandom_range(stall_cfg, 0));
                    stall_set  = 1'b1;
                end
                check("res_idx", res_idx, k_res);
                check("res_best", res_best, e_best);
                check("res_val", res_val, e_val);
                check("res_err", res_err, e_err);
                if (kill_kind == 2 && k_res == kill_k) begin
                    rst = 1'b0;
                    #1;
                    check_all_zero("rst_in_out");
                    repeat (2) @(negedge clk);
                    rst = 1'b1;
                    #1;
                    check("rst_release_ready", job_ready, 0);
                    tick();
                    check("rst_after_ready", job_ready, 1);
                    check("rst_after_busy", busy, 0);
                    for (int i = 0; i < 4; i++) begin
                        tick();
                        check("rst_no_result", res_valid, 0);
                        check("rst_no_done", job_done, 0);
                    end
                    return;
                end
                if (stall_left == 0) begin
                    res_ready = 1'b1;
                    k_res++;
                    stall_set = 1'b0;
                    if (k_res == n) exp_done_at = cyc + 1;
                    else exp_start_at = cyc + 1;
                end else begin
                    stall_left--;
                    // Stray completion while a result is pending must be ignored.
                    if ($urandom_range(1, 0) == 1) eng_done = 1'b1;
                end
            end
            if (job_done === 1'b1) begin
                check("job_done_timing", cyc, exp_done_at);
                fin = 1'b1;
            end
            tick();
            cyc++;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_ready", job_ready, 1);
                check("abort_res_valid", res_valid, 0);
                check("abort_eng_start", eng_start, 0);
                check("abort_results_before", k_res, kill_k);
                eng_done = 1'b1;
                eng_best = 4'hF;
                eng_val  = 8'hFF;
                tick();
                eng_done = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    check("late_done_no_result", res_valid, 0);
                    check("late_done_no_job_done", job_done, 0);
                    check("late_done_idle", busy, 0);
                    tick();
                end
                return;
            end
        end
        check("job_finished", fin, 1);
        check("start_count", k_start, n);
        check("result_count", k_res, n);
        check("job_done_one_pulse", job_done, 0);
        check("idle_ready", job_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        job_valid = 1'b0;
        job_base  = '0;
        job_nblk  = '0;
        abort     = 1'b0;
        eng_done  = 1'b0;
        eng_best  = '0;
        eng_val   = '0;
        res_ready = 1'b0;

        // Reset state, and job_ready rising one cycle after release.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_reset_ready_low", job_ready, 0);
        tick();
        check("post_reset_ready_high", job_ready, 1);

        // Four sub-blocks from 0x11, fixed engine latency, always ready.
        run_job(8'h11, 5'd4, 0, 0, 0, -1);
        // nblk=0 means 16 sub-blocks; positions wrap modulo 256.
        run_job(8'hF0, 5'd0, 0, 0, 0, -1);
        // Silent engine: every sub-block times out and the next is still issued.
        run_job(PW'($urandom), 5'd3, 2, 0, 0, -1);
        // Result held for 10 cycles of res_ready low.
        run_job(PW'($urandom), 5'd5, 1, -10, 0, -1);
        // Abort during WAIT of k=2, then a normal job starting at k=0.
        run_job(PW'($urandom), 5'd8, 1, 2, 1, 2);
        run_job(PW'($urandom), 5'd6, 1, 3, 0, -1);
        // Reset while presenting result k=3, then a normal job.
        run_job(PW'($urandom), 5'd6, 1, 4, 2, 3);
        run_job(PW'($urandom), 5'd2, 1, 2, 0, -1);
        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            run_job(PW'($urandom), 5'($urandom_range(16, 0)), 1, 3, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
